keypad_scan_ctrl: RTL
=====================

Name: keypad_scan_ctrl

Overview:
Scans a 4x4 matrix keypad (Pmod KYPD style, active-low rows, pulled-up columns), debounces the detected key and presents a 4-bit key code with a valid level and a one-cycle press strobe. Sits directly upstream of the processor: key_value drives the processor INREG input and key_valid drives its key-change input. Scan and debounce timing are derived from the system clock by an internal tick divider.

Parameters:
SCAN_DIV, 100000, clocks per scan tick (1 ms at 100 MHz); minimum 4.
DEBOUNCE_TICKS, 10, consecutive agreeing ticks needed to confirm a press or a release; minimum 1.
REPEAT_TICKS, 300, auto-repeat period in ticks; used only when KEYPAD_REPEAT_EN is defined.

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
col_in  input  4  keypad columns, asynchronous, 0 = pressed in the driven row
row_out  output  4  keypad row drive, one-hot active-low
key_value  output  4  code of the confirmed key = {row_idx[1:0], col_idx[1:0]}
key_valid  output  1  high while a confirmed key is held
key_pulse  output  1  one-clock strobe per confirmed press

Behaviour:
- Reset (async, reset_n=0): row_out=4'b1110 (row 0), key_value=0, key_valid=0, key_pulse=0, state SCAN, all counters 0, synchronizer flops 4'b1111.
- col_in passes through a 2-FF synchronizer (col_s); all decisions use col_s.
- Tick divider: counter 0..SCAN_DIV-1, wraps; tick=1 for one clock when the counter equals SCAN_DIV-1. Counter width $clog2(SCAN_DIV). Free-running in every state.
- A press is col_s != 4'b1111. On multiple low columns, the lowest column index wins (col 0 has the highest priority).
- FSM, evaluated only on tick cycles except where noted:
- SCAN: if press, latch cand={row_idx, col_idx}, clear db_cnt, go to DEBOUNCE, hold row. Else advance row_idx (3 wraps to 0), row_out follows.
- DEBOUNCE: row held. Same cand code seen: db_cnt++; when db_cnt reaches DEBOUNCE_TICKS, go to HOLD, key_value<=cand, key_valid<=1, key_pulse=1 for exactly one clock. Different code or no press: clear db_cnt, advance row, go to SCAN (no outputs change).
- HOLD: row held, key_valid=1. No press: clear db_cnt, go to RELEASE. A changed column while held is ignored.
- RELEASE: no press: db_cnt++; at DEBOUNCE_TICKS, key_valid<=0, advance row, go to SCAN. Press (any column) seen: clear db_cnt, go back to HOLD, no new pulse.
- key_value holds the last confirmed code after release, and changes only on a confirmed press.
- Latency: first tick with a stable press -> key_pulse after DEBOUNCE_TICKS further ticks. At most 4 ticks of scan delay before detection.
- key_pulse and key_valid are registered outputs, with no combinational path from col_in.
- Because SCAN_DIV>=4, each row drive settles through the synchronizer before it is sampled.
- Reset mid-operation: outputs drop to their reset values immediately, and no pulse is emitted.

Optional Feature:
KEYPAD_REPEAT_EN. When defined, a rep_cnt counts ticks in HOLD. When it reaches REPEAT_TICKS, key_pulse fires for one clock and rep_cnt clears, so the pulse repeats every REPEAT_TICKS ticks while the key is held. rep_cnt clears on entry to HOLD and on going to RELEASE. When not defined, there is exactly one key_pulse per confirmed press and no rep_cnt logic is generated.

Test Plan:
1. Bench parameters for all cases: SCAN_DIV=4, DEBOUNCE_TICKS=3. Reset, col_in=4'b1111 -> row_out=1110, key_valid=0, key_value=0; then row_out steps 1110->1101->1011->0111->1110, one step every 4 clocks.
2. Hold col_in=4'b1101 only while row_out=1011 (row 2, col 1) -> row_out freezes at 1011; 3 ticks later key_value=4'h9, key_valid=1, and key_pulse is high for exactly 1 clock.
3. Press as in 2 but release after 1 tick of DEBOUNCE -> return to SCAN, scanning resumes, no key_pulse, key_valid stays 0, key_value unchanged.
4. From HOLD of 4'h9: release for 1 tick then press again -> stays HOLD, no second pulse. Clean release for 3 ticks -> key_valid=0, key_value stays 4'h9, row advances to 0111.
5. col_in=4'b1010 during row 0 -> key_value=4'h0 (col 0 wins), single pulse.
6. Assert reset_n=0 mid-HOLD -> same cycle: key_valid=0, key_value=0, row_out=1110. With KEYPAD_REPEAT_EN and REPEAT_TICKS=5, a held key -> pulses at confirmation and then every 5 ticks.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 matrix keypad scanner with debounce for a Pmod KYPD style pad.
// Rows are driven one-hot active-low and columns are pulled up. The debounced key is
// presented as {row, col} with a held-level valid and a one-clock press strobe.
// Build option: define KEYPAD_REPEAT_EN to add auto-repeat press strobes while a key is held.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// SCAN     | step one row per tick, looking for any low column
// DEBOUNCE | row frozen, the same candidate code must persist for DEBOUNCE_TICKS
// HOLD     | key confirmed, key_valid high, waiting for the columns to go quiet
// RELEASE  | no press seen; must stay quiet DEBOUNCE_TICKS ticks to drop key_valid
module keypad_scan_ctrl #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_TICKS = 10,
    parameter int REPEAT_TICKS   = 300
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_value,
    output logic       key_valid,
    output logic       key_pulse
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DB_W  = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS + 1) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_TICKS - 1);

    // Parameter sanity: a divider under 4 would sample a row before the
    // synchronizer has seen the new drive.
    if (SCAN_DIV < 4 || DEBOUNCE_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_params
        $error("keypad_scan_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HOLD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [3:0]       col_meta;
    logic [3:0]       col_s;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    logic [1:0]       row_idx;
    logic [1:0]       col_idx;
    logic             press;
    logic [3:0]       scan_code;
    logic [3:0]       cand;
    logic             cand_match;

    logic [DB_W-1:0]  db_cnt;
    logic             db_last;

    logic             load_cand;
    logic             db_inc;
    logic             db_clr;
    logic             adv_row;
    logic             confirm;
    logic             release_done;
    logic             pulse_set;

    // Two-flop synchronizer on the asynchronous column inputs (idle = pulled up).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_meta <= 4'b1111;
            col_s    <= 4'b1111;
        end else begin
            col_meta <= col_in;
            col_s    <= col_meta;
        end
    end

    // Free-running scan tick divider.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    // Column priority encode: the lowest low column wins.
    always_comb begin
        col_idx = 2'd0;
        if (!col_s[0]) begin
            col_idx = 2'd0;
        end else if (!col_s[1]) begin
            col_idx = 2'd1;
        end else if (!col_s[2]) begin
            col_idx = 2'd2;
        end else if (!col_s[3]) begin
            col_idx = 2'd3;
        end
    end

    assign press      = (col_s != 4'b1111);
    assign scan_code  = {row_idx, col_idx};
    assign cand_match = press && (scan_code == cand);
    assign db_last    = (db_cnt == DB_LAST);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_SCAN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; transitions only happen on tick cycles.
    always_comb begin
        state_next = state;
        if (tick) begin
            case (state)
                ST_SCAN: begin
                    if (press) begin
                        state_next = ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!cand_match) begin
                        state_next = ST_SCAN;
                    end else if (db_last) begin
                        state_next = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!press) begin
                        state_next = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (press) begin
                        state_next = ST_HOLD;
                    end else if (db_last) begin
                        state_next = ST_SCAN;
                    end
                end
                default: state_next = ST_SCAN;
            endcase
        end
    end

    // Per-state datapath actions for the current tick.
    always_comb begin
        load_cand    = 1'b0;
        db_inc       = 1'b0;
        db_clr       = 1'b0;
        adv_row      = 1'b0;
        confirm      = 1'b0;
        release_done = 1'b0;
        if (tick) begin
            case (state)
                ST_SCAN: begin
                    if (press) begin
                        load_cand = 1'b1;
                        db_clr    = 1'b1;
                    end else begin
                        adv_row   = 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!cand_match) begin
                        db_clr  = 1'b1;
                        adv_row = 1'b1;
                    end else if (db_last) begin
                        confirm = 1'b1;
                        db_clr  = 1'b1;
                    end else begin
                        db_inc  = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!press) begin
                        db_clr = 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (press) begin
                        db_clr       = 1'b1;
                    end else if (db_last) begin
                        release_done = 1'b1;
                        db_clr       = 1'b1;
                        adv_row      = 1'b1;
                    end else begin
                        db_inc       = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS + 1) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_TICKS - 1);

    logic [REP_W-1:0] rep_cnt;
    logic             rep_fire;
    logic             rep_inc;
    logic             rep_clr;

    // Auto-repeat: count held ticks in HOLD; restart whenever HOLD is (re)entered.
    always_comb begin
        rep_fire = 1'b0;
        rep_inc  = 1'b0;
        rep_clr  = confirm;
        if (tick && state == ST_HOLD) begin
            if (!press) begin
                rep_clr = 1'b1;
            end else if (rep_cnt == REP_LAST) begin
                rep_fire = 1'b1;
                rep_clr  = 1'b1;
            end else begin
                rep_inc  = 1'b1;
            end
        end else if (tick && state == ST_RELEASE && press) begin
            rep_clr = 1'b1;
        end
    end

    // Repeat counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rep_cnt <= '0;
        end else if (rep_clr) begin
            rep_cnt <= '0;
        end else if (rep_inc) begin
            rep_cnt <= rep_cnt + 1'b1;
        end
    end

    assign pulse_set = confirm | rep_fire;
`else
    assign pulse_set = confirm;
`endif

    // Row pointer, candidate, debounce counter and the registered key outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_idx   <= 2'd0;
            cand      <= 4'd0;
            db_cnt    <= '0;
            key_value <= 4'd0;
            key_valid <= 1'b0;
            key_pulse <= 1'b0;
        end else begin
            key_pulse <= pulse_set;
            if (adv_row) begin
                row_idx <= row_idx + 2'd1;
            end
            if (load_cand) begin
                cand <= scan_code;
            end
            if (db_clr) begin
                db_cnt <= '0;
            end else if (db_inc) begin
                db_cnt <= db_cnt + 1'b1;
            end
            if (confirm) begin
                key_value <= cand;
                key_valid <= 1'b1;
            end else if (release_done) begin
                key_valid <= 1'b0;
            end
        end
    end

    // One-hot active-low row drive follows the row pointer.
    always_comb begin
        row_out          = 4'b1111;
        row_out[row_idx] = 1'b0;
    end

endmodule
